io_input_reader: RTL and testbench
==================================

# io_input_reader

Memory-mapped input peripheral for the single-cycle RISC-V core; the read-side counterpart of the LED output driver. It synchronises and debounces up to N_BUTTONS asynchronous push-button pads and records rising edges in sticky pending bits. The CPU reads both through the load path. Reading the event word clears the bits it returned. It shares the IO address window and decode style with the LED driver and drives the load-data mux when selected.

## Interface
- N_BUTTONS, 5: number of button inputs, 1..32.
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required to accept a new level, ≥2.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset); release is synchronous to clk at top level.
- readEnable  in  1  CPU load strobe for the current instruction.
- addr  in  32  CPU data address; word address = addr[31:2].
- buttons  in  N_BUTTONS  raw pad levels, asynchronous, active-high.
- isIO  out  1  combinational: addr hits a register of this block.
- rdata  out  32  combinational read data; zero-extended.
- irq  out  1  registered: OR of all pending bits.

## Operation
- Decode is one-hot on the word address:
  - wordAddr[1] (addr[3]) selects LEVEL.
  - wordAddr[2] (addr[4]) selects EVENT.
  - If both are set, EVENT wins.
  - isIO = wordAddr[1] | wordAddr[2].
- rdata:
  - LEVEL selected: {0, stable}.
  - EVENT selected: {0, pending}.
  - Otherwise 32'b0.
  - rdata is independent of readEnable.
- Per bit, a 2-flop synchroniser: sync1 <= buttons, sync2 <= sync1.
- Debounce (per bit, counter width $clog2(DEBOUNCE_CYCLES)):
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A bounce back to the old level before acceptance restarts the count.
- Pending bit: set on the edge where stable transitions 0->1. Falling transitions never set it.
- Read-to-clear: on an edge where readEnable & EVENT selected, pending <= pending & ~rdata_snapshot. Only bits that were 1 in the returned value are cleared.
- Simultaneous set and clear on the same bit in the same edge: set wins, so the bit stays 1 and no event is lost.
- LEVEL reads have no side effects.
- Reset, including mid-count: sync1, sync2, stable, cnt, pending and irq are all cleared immediately and asynchronously.

## Timing
- Reset values:
  - rdata = 0 for LEVEL/EVENT reads.
  - irq = 0.
  - isIO follows addr combinationally, even in reset.
- Pad level change sampled at edge E0:
  - sync2 differs from stable after E1.
  - stable updates at edge E1+DEBOUNCE_CYCLES, provided the level holds.
  - pending sets at that same edge.
  - irq rises one edge later.
- Read clear: pending bit is 0 after the edge ending the read cycle; irq falls one edge later if no bits remain.
- A held button produces exactly one pending set per press; release needs its own DEBOUNCE_CYCLES window.
- No backpressure: single-cycle access, zero wait states.

## Configuration
- IO_INPUT_DEBOUNCE_EN defined:
  - Debounce counters are instantiated as above.
- IO_INPUT_DEBOUNCE_EN undefined:
  - No counters.
  - stable <= sync2 every edge.
  - Pad change at E0 reaches stable and sets pending at E2.
  - DEBOUNCE_CYCLES is ignored.
  - Decode, read-to-clear and irq behaviour are identical.

## Test plan
- Reset: run with DEBOUNCE_CYCLES=4 and buttons=5'b11111 held during reset.
  - Stimulus: assert reset mid-count.
  - Required: LEVEL=0, EVENT=0, irq=0; after release, LEVEL=0x1F and EVENT=0x1F after 1+4 edges.
- Debounce reject: toggle buttons[0] high for 3 cycles, then low, with DEBOUNCE_CYCLES=4.
  - Required: LEVEL stays 0, EVENT stays 0, irq never asserts.
- Clean press: buttons[2] 0->1 at E0.
  - Required: LEVEL=0x4 at E5, EVENT=0x4, irq=1 at E6.
  - Then read EVENT (addr=0x10, readEnable=1): returns 0x4, EVENT=0 after that edge, irq=0 one edge later.
- Set/clear collision: EVENT=0x1 and buttons[1] accepted on the same edge as a read-clear.
  - Required: read returns 0x1; EVENT afterwards = 0x2.
  - Repeat with buttons[0] re-accepted on the clearing edge: EVENT stays 0x1.
- Decode: addr=0x8 -> isIO=1 with LEVEL data; addr=0x10 -> isIO=1 with EVENT data.
  - addr=0x4 or 0x0 -> isIO=0, rdata=0.
  - LEVEL read with readEnable=1 leaves EVENT unchanged.
- Macro off: build without IO_INPUT_DEBOUNCE_EN, then buttons[3] 0->1 at E0.
  - Required: LEVEL=0x8 and EVENT=0x8 at E2; a 1-cycle glitch is also captured as an event.

Source files
------------

// File: rtl/io_input_reader.sv
// Memory-mapped button input peripheral: 2-flop synchroniser, optional debounce
// (enabled by defining IO_INPUT_DEBOUNCE_EN), sticky rising-edge events with read-to-clear.
module io_input_reader #(
  parameter int N_BUTTONS       = 5,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readEnable,
  input  logic [31:0]          addr,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic                 isIO,
  output logic [31:0]          rdata,
  output logic                 irq
);

  logic [29:0]          word_addr_s;
  logic                 level_sel_s;
  logic                 event_sel_s;
  logic                 unused_addr_s;
  logic [N_BUTTONS-1:0] sync1_r;
  logic [N_BUTTONS-1:0] sync2_r;
  logic [N_BUTTONS-1:0] stable_r;
  logic [N_BUTTONS-1:0] stable_nxt_s;
  logic [N_BUTTONS-1:0] pending_r;
  logic [N_BUTTONS-1:0] pending_nxt_s;
  logic [N_BUTTONS-1:0] rise_s;
  logic [N_BUTTONS-1:0] clear_s;
  logic                 irq_r;

  assign word_addr_s   = addr[31:2];
  assign level_sel_s   = word_addr_s[1];
  assign event_sel_s   = word_addr_s[2];
  assign unused_addr_s = ^{word_addr_s[29:3], word_addr_s[0], addr[1:0]};

  // Address decode and load-data mux; EVENT has priority over LEVEL.
  always_comb begin
    isIO  = level_sel_s | event_sel_s;
    rdata = 32'd0;
    if (event_sel_s) begin
      rdata = 32'(pending_r);
    end else if (level_sel_s) begin
      rdata = 32'(stable_r);
    end else begin
      rdata = 32'd0;
    end
  end

  // Two-stage synchroniser for the asynchronous pads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= buttons;
      sync2_r <= sync1_r;
    end
  end

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r     [N_BUTTONS];
  logic [CNT_W-1:0] cnt_nxt_s [N_BUTTONS];

  // A new level is accepted only after it has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    stable_nxt_s = stable_r;
    cnt_nxt_s    = cnt_r;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (sync2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i]    = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  localparam int UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;

  // Without debounce the synchronised level is taken directly.
  always_comb begin
    stable_nxt_s = sync2_r;
  end
`endif

  // Rising edges set pending; an EVENT read clears what it returned, but a set wins.
  always_comb begin
    rise_s        = stable_nxt_s & ~stable_r;
    clear_s       = '0;
    if (readEnable && event_sel_s) begin
      clear_s = rdata[N_BUTTONS-1:0];
    end else begin
      clear_s = '0;
    end
    pending_nxt_s = (pending_r & ~clear_s) | rise_s;
  end

  // Accepted level, sticky events and the registered interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_r  <= '0;
      pending_r <= '0;
      irq_r     <= 1'b0;
    end else begin
      stable_r  <= stable_nxt_s;
      pending_r <= pending_nxt_s;
      irq_r     <= |pending_r;
    end
  end

  assign irq = irq_r;

endmodule

// File: tb/tb_io_input_reader.sv
// Scoreboard bench for io_input_reader: a window-based reference model predicts
// isIO/rdata/irq each cycle; a negedge monitor pops and compares.
module tb_io_input_reader;

  localparam int N = 5;
  localparam int D = 4;
`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int W = D;
`else
  localparam int W = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          readEnable;
  logic [31:0]   addr;
  logic [N-1:0]  buttons;
  logic          isIO;
  logic [31:0]   rdata;
  logic          irq;

  io_input_reader #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .readEnable(readEnable), .addr(addr),
    .buttons(buttons), .isIO(isIO), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        io;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;

  // Reference model: a level is accepted once the last W synchronised samples
  // all disagree with the current accepted level.
  logic [N-1:0] m_stable;
  logic [N-1:0] m_pend;
  logic         m_irq;
  logic [N-1:0] samp[$];

  task automatic model_reset();
    m_stable = '0;
    m_pend   = '0;
    m_irq    = 1'b0;
    samp.delete();
    for (int i = 0; i < W + 1; i++) samp.push_back('0);
  endtask

  task automatic model_edge(input logic re, input logic [31:0] a, input logic [N-1:0] pad);
    logic [N-1:0] flip;
    logic [N-1:0] new_st;
    logic [N-1:0] clr;
    flip = '1;
    for (int i = 0; i < W; i++) flip &= samp[i] ^ m_stable;
    new_st   = m_stable ^ flip;
    clr      = (re && a[4]) ? m_pend : '0;
    m_irq    = |m_pend;
    m_pend   = (m_pend & ~clr) | (new_st & ~m_stable);
    m_stable = new_st;
    samp.push_back(pad);
    if (samp.size() > W + 1) void'(samp.pop_front());
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.io  = addr[3] | addr[4];
    e.rd  = addr[4] ? 32'(m_pend) : (addr[3] ? 32'(m_stable) : 32'd0);
    e.irq = m_irq;
    return e;
  endfunction

  // One clock: advance the model over the edge, then apply new inputs and queue expectations.
  task automatic cycle(input logic rst_v, input logic re, input logic [31:0] a, input logic [N-1:0] b);
    @(posedge clk);
    if (reset) model_edge(readEnable, addr, buttons);
    #1;
    reset      = rst_v;
    readEnable = re;
    addr       = a;
    buttons    = b;
    if (!reset) model_reset();
    exp_q.push_back(expect_now());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("isIO", {31'd0, isIO}, {31'd0, mon_e.io});
      check("rdata", rdata, mon_e.rd);
      check("irq", {31'd0, irq}, {31'd0, mon_e.irq});
    end
  end

  logic [31:0] atab [6];
  logic [N-1:0] bv;

  initial begin
    atab = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h18, 32'hC};
    reset = 1'b0; readEnable = 1'b0; addr = 32'h8; buttons = '1;
    model_reset();

    // Reset with all pads high, release, then reset again mid-count.
    repeat (3) cycle(1'b0, 1'b0, 32'h10, 5'h1F);
    repeat (3) cycle(1'b1, 1'b0, 32'h8, 5'h1F);
    cycle(1'b0, 1'b0, 32'h8, 5'h1F);
    cycle(1'b0, 1'b0, 32'h10, 5'h1F);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, (i % 2) ? 32'h8 : 32'h10, 5'h1F);
    cycle(1'b1, 1'b1, 32'h10, 5'h1F);
    repeat (3) cycle(1'b1, 1'b0, 32'h10, 5'h1F);

    // Release everything and clear.
    repeat (W + 6) cycle(1'b1, 1'b0, 32'h8, 5'h00);
    cycle(1'b1, 1'b1, 32'h10, 5'h00);
    repeat (2) cycle(1'b1, 1'b0, 32'h10, 5'h00);

    // Short glitch on bit 0.
    repeat (3) cycle(1'b1, 1'b0, 32'h10, 5'h01);
    repeat (W + 6) cycle(1'b1, 1'b0, 32'h10, 5'h00);
    cycle(1'b1, 1'b1, 32'h10, 5'h00);

    // Clean press of bit 2 and read-to-clear.
    repeat (W + 4) cycle(1'b1, 1'b0, 32'h10, 5'h04);
    cycle(1'b1, 1'b1, 32'h10, 5'h04);
    repeat (3) cycle(1'b1, 1'b0, 32'h10, 5'h04);

    // Decode corners; LEVEL read must not clear events.
    cycle(1'b1, 1'b0, 32'h4, 5'h04);
    cycle(1'b1, 1'b0, 32'h0, 5'h04);
    cycle(1'b1, 1'b1, 32'h8, 5'h04);
    cycle(1'b1, 1'b0, 32'h18, 5'h04);
    repeat (W + 6) cycle(1'b1, 1'b0, 32'h8, 5'h00);
    cycle(1'b1, 1'b1, 32'h10, 5'h00);

    // Set/clear collision sweep: read lands on every edge around acceptance.
    for (int k = 0; k < W + 4; k++) begin
      repeat (W + 4) cycle(1'b1, 1'b0, 32'h10, 5'h01);
      repeat (k) cycle(1'b1, 1'b0, 32'h10, 5'h03);
      cycle(1'b1, 1'b1, 32'h10, 5'h03);
      repeat (W + 4) cycle(1'b1, 1'b0, 32'h10, 5'h02);
      repeat (k) cycle(1'b1, 1'b0, 32'h10, 5'h03);
      cycle(1'b1, 1'b1, 32'h10, 5'h03);
      repeat (W + 4) cycle(1'b1, 1'b0, 32'h8, 5'h00);
      cycle(1'b1, 1'b1, 32'h10, 5'h00);
    end

    // Randomised traffic with occasional mid-run resets.
    bv = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bv[$urandom_range(0, N - 1)] ^= 1'b1;
      cycle(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1,
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            atab[$urandom_range(0, 5)], bv);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
